// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that owns the shared instruction/data
// memory port, holds the program counter and hands fetched words to decode
// over a valid/ready handshake. Data loads/stores pre-empt the fetch slot and
// branch redirects flush everything buffered.
//
// Build option: FETCH_PREFETCH_EN
//   defined   - output buffer is a 2-entry FIFO, so fetch runs one entry ahead
//               while decode stalls (no combinational instrReady -> capture path)
//   undefined - output buffer is a single register; a new word may land in the
//               same cycle the held word is accepted
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd128,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWriteEnable,
    input  logic [31:0] memData,
    input  logic        dataReq,
    input  logic        dataWrite,
    input  logic [31:0] dataAddress,
    input  logic [31:0] dataWriteData,
    output logic [31:0] dataReadData,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    input  logic        haltReq,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic        instrValid,
    input  logic        instrReady,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STALL  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t      state_r;
    logic        boot_done_r;
    logic        halted_r;
    logic [31:0] pc_r;
    logic [1:0]  count_r;
    logic        valid_r;
    logic [31:0] head_instr_r;
    logic [31:0] head_pc_r;
`ifdef FETCH_PREFETCH_EN
    logic [31:0] tail_instr_r;
    logic [31:0] tail_pc_r;
`endif

    logic        pop_s;
    logic        space_s;
    logic        capture_s;

    // Decide whether decode drains the head and whether a fetched word may land.
    always_comb begin
        pop_s     = valid_r & instrReady;
`ifdef FETCH_PREFETCH_EN
        space_s   = (count_r < 2'd2);
`else
        space_s   = (count_r == 2'd0) | pop_s;
`endif
        capture_s = (state_r == ST_FETCH) & ~dataReq & ~redirectValid & ~haltReq & space_s;
    end

    // Shared memory port: data accesses pre-empt the fetch address this cycle.
    always_comb begin
        if (!Rst_n) begin
            memAddress     = RESET_PC;
            memWriteEnable = 1'b0;
            memWriteData   = 32'd0;
        end else if (dataReq) begin
            memAddress     = dataAddress;
            memWriteEnable = dataWrite;
            memWriteData   = dataWriteData;
        end else begin
            memAddress     = pc_r;
            memWriteEnable = 1'b0;
            memWriteData   = 32'd0;
        end
    end

    // Control FSM, program counter and output buffer.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r      <= ST_BOOT;
            boot_done_r  <= 1'b0;
            halted_r     <= 1'b0;
            pc_r         <= RESET_PC;
            count_r      <= 2'd0;
            valid_r      <= 1'b0;
            head_instr_r <= 32'd0;
            head_pc_r    <= 32'd0;
`ifdef FETCH_PREFETCH_EN
            tail_instr_r <= 32'd0;
            tail_pc_r    <= 32'd0;
`endif
        end else begin
            // The first edge after reset release only arms BOOT's exit.
            boot_done_r <= 1'b1;

            case (state_r)
                ST_BOOT: begin
                    state_r  <= boot_done_r ? ST_FETCH : ST_BOOT;
                    halted_r <= 1'b0;
                end
                ST_FETCH, ST_STALL: begin
                    if (redirectValid) begin
                        state_r  <= ST_FETCH;
                        halted_r <= 1'b0;
                    end else if (haltReq) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end else if (space_s) begin
                        state_r  <= ST_FETCH;
                        halted_r <= 1'b0;
                    end else begin
                        state_r  <= ST_STALL;
                        halted_r <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (redirectValid) begin
                        state_r  <= ST_FETCH;
                        halted_r <= 1'b0;
                    end else begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_BOOT;
                    halted_r <= 1'b0;
                end
            endcase

            // Redirect wins over sequential advance; targets are word aligned.
            if (redirectValid) begin
                pc_r <= redirectTarget & 32'hFFFF_FFFC;
            end else if (capture_s) begin
                pc_r <= pc_r + PC_STEP;
            end else begin
                pc_r <= pc_r;
            end

            // Buffer update: flush, replace-on-drain, push, or pop.
            if (redirectValid) begin
                count_r <= 2'd0;
                valid_r <= 1'b0;
            end else if (capture_s && pop_s) begin
                // Only reachable with a single entry held, so the new word becomes head.
                head_instr_r <= memData;
                head_pc_r    <= pc_r;
            end else if (capture_s) begin
`ifdef FETCH_PREFETCH_EN
                if (count_r == 2'd0) begin
                    head_instr_r <= memData;
                    head_pc_r    <= pc_r;
                end else begin
                    tail_instr_r <= memData;
                    tail_pc_r    <= pc_r;
                end
`else
                head_instr_r <= memData;
                head_pc_r    <= pc_r;
`endif
                count_r <= count_r + 2'd1;
                valid_r <= 1'b1;
            end else if (pop_s) begin
`ifdef FETCH_PREFETCH_EN
                head_instr_r <= tail_instr_r;
                head_pc_r    <= tail_pc_r;
`endif
                count_r <= count_r - 2'd1;
                valid_r <= (count_r == 2'd2);
            end else begin
                count_r <= count_r;
                valid_r <= valid_r;
            end
        end
    end

    assign dataReadData = memData;
    assign instr        = head_instr_r;
    assign instrPc      = head_pc_r;
    assign instrValid   = valid_r;
    assign halted       = halted_r;

endmodule
